l1_i_controller: RTL and testbench
==================================

# l1_i_controller

Sequencing controller for the 2-way set-associative L1 instruction cache. It accepts CPU fetch requests and holds the tag, valid and LRU state. It drives index, offset, way and refill into `L1_I_data_array`, and runs the miss handshake with L2. It sits between the fetch stage and the L1_I data array / L2 interface.

## Interface

**Parameters**
- `TNUM`, 21, number of tag bits.
- `INUM`, 26 - TNUM, number of index bits; sets = 2^INUM.
- `OFFS`, 6, number of line offset bits (64-byte line).

**Ports**
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `read_C_L1` in 1: CPU fetch request.
- `address_C_L1` in 32: fetch byte address; split as tag = [31:32-TNUM], index = [OFFS+:INUM], offset = [0+:OFFS].
- `flush` in 1: invalidate all lines.
- `ready_L1_C` out 1: one-cycle strobe; `read_data_L1_C` from the data array is valid this cycle.
- `index_C_L1` out INUM: set index to the data array.
- `offset` out OFFS: byte offset to the data array.
- `way` out 1: way select to the data array.
- `refill` out 1: write strobe to the data array.
- `read_L1_L2` out 1: line request to L2.
- `address_L1_L2` out 32: line-aligned miss address, with the low OFFS bits zero.
- `ready_L2_L1` in 1: L2 has `read_data_L2_L1` valid.

## Operation

- State per set: `tag[2]`, `valid[2]`, `lru` (the way to evict next).
- FSM states: IDLE, COMPARE, ALLOCATE, REFILL.
- **IDLE**
  - If `flush`=1: clear all valid bits and lru in one edge; a concurrent `read_C_L1` is not accepted.
  - Else if `read_C_L1`=1: latch the address and go to COMPARE.
- **COMPARE**
  - Hit: `valid[w]` && `tag[w]==tag` for some way w.
    - Drive `way`=w and `ready_L1_C`=1 for this cycle.
    - Set `lru`=~w.
    - Go to IDLE.
  - Miss: choose victim v = first invalid way (way 0 before way 1), else `lru`.
    - Latch v and go to ALLOCATE.
- **ALLOCATE**
  - Hold `read_L1_L2`=1 and `address_L1_L2`={latched tag, index, 0}.
  - Wait for `ready_L2_L1`=1, then go to REFILL.
- **REFILL**
  - Drive `refill`=1 and `way`=v for exactly one cycle.
  - Write `tag[v]`, set `valid[v]`=1, set `lru`=~v.
  - Go to COMPARE; this compare is now a guaranteed hit.
- `index_C_L1` and `offset` come from the latched address in every state except IDLE.
- Inputs are ignored outside the states that use them:
  - `read_C_L1` is ignored outside IDLE; the CPU holds its request until it sees `ready_L1_C`.
  - `flush` is ignored outside IDLE.
  - `ready_L2_L1` is ignored outside ALLOCATE.
- `way` outside COMPARE and REFILL is the latched victim, or 0 after reset.

## Timing

- Reset values:
  - State IDLE.
  - All valid bits 0, all lru 0.
  - Latched address 0.
  - Every output 0.
- Reset mid-operation, including ALLOCATE: everything returns to the reset values at the same edge, and `read_L1_L2` is low the next cycle. An L2 response arriving afterwards is ignored.
- Hit latency: request sampled at edge k; `ready_L1_C` is high in cycle k+1.
- Miss latency: with `ready_L2_L1` in the first ALLOCATE cycle, `read_L1_L2` is high in cycle k+2 and `refill` in cycle k+3. `ready_L1_C` is high in cycle k+4; each extra L2 wait cycle adds one.
- `read_L1_L2` is driven from state; it drops at the edge where ALLOCATE is left.
- The data array captures the line on the edge that ends REFILL.
- Back-to-back requests: a new request is accepted, at the earliest, in the IDLE cycle after `ready_L1_C`. Minimum spacing is 2 cycles.
- Index wrap: all 2^INUM sets are independent, and index 2^INUM-1 needs no special case.

## Structure

- Package `l1_i_pkg` holds:
  - The state enum `l1_i_state_t`.
  - The constants `OFFS`, `WAYS`=2, and the default `TNUM`/`INUM`.
- Sub-module `l1_i_tag_array` holds the tag/valid/lru registers. It provides:
  - A combinational hit and hit-way lookup.
  - Victim selection.
  - A one-cycle write port.
  - Flush and reset clear.
- The FSM, the address latch and the L2 handshake live in `l1_i_controller`.

## Test plan

- **Reset:** hold `rst` 3 cycles → all outputs 0; a request right after release is a miss.
- **Cold miss:** address 0x1234_5048, `ready_L2_L1` 3 cycles after `read_L1_L2` rises → `address_L1_L2`=0x1234_5040, `refill`=1 for one cycle with `way`=0, `ready_L1_C` high one cycle later.
- **Hit:** address 0x1234_507C after the cold miss → `ready_L1_C` one cycle after the request, `way`=0, `offset`=0x3C, `read_L1_L2` never rises.
- **Conflict:**
  - 0xABCD_E040 (same index, new tag) → fills way 1.
  - Then a hit on 0x1234_5040 sets lru=1.
  - Then 0x5555_5040 → victim way 1.
  - 0x1234_5040 still hits in way 0.
- **Flush:** `flush` in IDLE together with `read_C_L1` → request not accepted that cycle; the next access to 0x1234_5040 misses.
- **Reset in ALLOCATE:** `rst` with `read_L1_L2` high → `read_L1_L2` low the next cycle; a late `ready_L2_L1` pulse produces no `refill`.

Source files
------------

// File: rtl/l1_i_pkg.sv
// Shared types and constants for the L1 instruction cache controller.
package l1_i_pkg;

    localparam int OFFS = 6;
    localparam int WAYS = 2;
    localparam int TNUM_DEFAULT = 21;
    localparam int INUM_DEFAULT = 26 - TNUM_DEFAULT;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        ALLOCATE,
        REFILL
    } l1_i_state_t;

endpackage

// File: rtl/l1_i_tag_array.sv
// Tag, valid and LRU storage for the 2-way L1 I-cache, with lookup and victim pick.
module l1_i_tag_array #(
    parameter int TNUM = l1_i_pkg::TNUM_DEFAULT,
    parameter int INUM = l1_i_pkg::INUM_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic [INUM-1:0] lk_index,
    input  logic [TNUM-1:0] lk_tag,
    output logic            hit,
    output logic            hit_way,
    output logic            victim,
    input  logic            upd_en,
    input  logic            upd_way,
    input  logic            fill
);
    import l1_i_pkg::*;

    localparam int SETS = 1 << INUM;

    logic [TNUM-1:0] tag_q [WAYS][SETS];
    logic [WAYS-1:0] valid_q [SETS];
    logic [SETS-1:0] lru_q;

    logic h0;
    logic h1;

    always_comb begin
        h0 = valid_q[lk_index][0] && (tag_q[0][lk_index] == lk_tag);
        h1 = valid_q[lk_index][1] && (tag_q[1][lk_index] == lk_tag);
        hit = h0 | h1;
        hit_way = h1 & ~h0;
        // Empty ways are filled in order before the LRU way is evicted
        if (!valid_q[lk_index][0]) begin
            victim = 1'b0;
        end else if (!valid_q[lk_index][1]) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[lk_index];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
            lru_q <= '0;
        end else if (upd_en) begin
            lru_q[lk_index] <= ~upd_way;
            if (fill) begin
                valid_q[lk_index][upd_way] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (upd_en && fill) begin
            tag_q[upd_way][lk_index] <= lk_tag;
        end
    end

endmodule

// File: rtl/l1_i_controller.sv
// L1 I-cache sequencer: fetch FSM, address latch and L2 miss handshake.
module l1_i_controller #(
    parameter int TNUM = l1_i_pkg::TNUM_DEFAULT,
    parameter int INUM = 26 - TNUM,
    parameter int OFFS = l1_i_pkg::OFFS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            read_C_L1,
    input  logic [31:0]     address_C_L1,
    input  logic            flush,
    output logic            ready_L1_C,
    output logic [INUM-1:0] index_C_L1,
    output logic [OFFS-1:0] offset,
    output logic            way,
    output logic            refill,
    output logic            read_L1_L2,
    output logic [31:0]     address_L1_L2,
    input  logic            ready_L2_L1
);
    import l1_i_pkg::*;

    l1_i_state_t state_q;
    l1_i_state_t state_d;

    logic [31:0]     addr_q;
    logic            victim_q;
    logic [TNUM-1:0] tag_l;
    logic [INUM-1:0] idx_l;

    logic hit;
    logic hit_way;
    logic victim;
    logic clear;
    logic latch;
    logic vlatch;
    logic upd_en;
    logic upd_way;
    logic fill;

    assign tag_l = addr_q[31 -: TNUM];
    assign idx_l = addr_q[OFFS +: INUM];

    l1_i_tag_array #(
        .TNUM(TNUM),
        .INUM(INUM)
    ) u_tags (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .lk_index(idx_l),
        .lk_tag  (tag_l),
        .hit     (hit),
        .hit_way (hit_way),
        .victim  (victim),
        .upd_en  (upd_en),
        .upd_way (upd_way),
        .fill    (fill)
    );

    always_comb begin
        state_d = state_q;
        ready_L1_C = 1'b0;
        refill = 1'b0;
        read_L1_L2 = 1'b0;
        address_L1_L2 = '0;
        way = victim_q;
        index_C_L1 = '0;
        offset = '0;
        clear = 1'b0;
        latch = 1'b0;
        vlatch = 1'b0;
        upd_en = 1'b0;
        upd_way = 1'b0;
        fill = 1'b0;
        if (state_q != IDLE) begin
            index_C_L1 = idx_l;
            offset = addr_q[OFFS-1:0];
        end
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    clear = 1'b1;
                end else if (read_C_L1) begin
                    latch = 1'b1;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    ready_L1_C = 1'b1;
                    way = hit_way;
                    upd_en = 1'b1;
                    upd_way = hit_way;
                    state_d = IDLE;
                end else begin
                    vlatch = 1'b1;
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                read_L1_L2 = 1'b1;
                address_L1_L2 = {tag_l, idx_l, {OFFS{1'b0}}};
                if (ready_L2_L1) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                refill = 1'b1;
                way = victim_q;
                upd_en = 1'b1;
                upd_way = victim_q;
                fill = 1'b1;
                state_d = COMPARE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q <= '0;
            victim_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                addr_q <= address_C_L1;
            end
            if (vlatch) begin
                victim_q <= victim;
            end
        end
    end

endmodule

// File: tb/tb_l1_i_controller.sv
// Randomized bench for l1_i_controller against a set/way reference model.
module tb_l1_i_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_C_L1 = 1'b0;
    logic [31:0] address_C_L1 = '0;
    logic        flush = 1'b0;
    logic        ready_L2_L1 = 1'b0;
    logic        ready_L1_C;
    logic [4:0]  index_C_L1;
    logic [5:0]  offset;
    logic        way;
    logic        refill;
    logic        read_L1_L2;
    logic [31:0] address_L1_L2;

    int tests = 0;
    int fails = 0;

    logic [20:0] m_tag [32][2];
    bit          m_val [32][2];
    bit          m_lru [32];

    always #5 clk = ~clk;

    l1_i_controller dut (
        .clk          (clk),
        .rst          (rst),
        .read_C_L1    (read_C_L1),
        .address_C_L1 (address_C_L1),
        .flush        (flush),
        .ready_L1_C   (ready_L1_C),
        .index_C_L1   (index_C_L1),
        .offset       (offset),
        .way          (way),
        .refill       (refill),
        .read_L1_L2   (read_L1_L2),
        .address_L1_L2(address_L1_L2),
        .ready_L2_L1  (ready_L2_L1)
    );

    task automatic chk(input string nm, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 32; s++) begin
            m_val[s][0] = 0;
            m_val[s][1] = 0;
            m_lru[s] = 0;
        end
    endtask

    task automatic fetch(input logic [31:0] a, input int l2_wait);
        logic [4:0]  s;
        logic [20:0] t;
        bit          hit;
        bit          w;
        int cyc, alloc, rise_cyc, ref_cyc, nref, rdy_cyc;
        logic ref_way, rdy_way;
        logic [4:0] rdy_idx;
        logic [5:0] rdy_off;
        logic [31:0] l2_addr;
        s = a[10:6];
        t = a[31:11];
        if (m_val[s][0] && m_tag[s][0] == t) begin
            hit = 1; w = 0;
        end else if (m_val[s][1] && m_tag[s][1] == t) begin
            hit = 1; w = 1;
        end else begin
            hit = 0;
            w = !m_val[s][0] ? 1'b0 : (!m_val[s][1] ? 1'b1 : m_lru[s]);
            m_val[s][w] = 1;
            m_tag[s][w] = t;
        end
        m_lru[s] = !w;

        @(negedge clk);
        read_C_L1 = 1'b1;
        address_C_L1 = a;
        @(negedge clk);
        read_C_L1 = 1'b0;
        cyc = 1; alloc = 0; rise_cyc = 0; ref_cyc = 0; nref = 0;
        rdy_cyc = 0; ref_way = 0; rdy_way = 0; rdy_idx = 0; rdy_off = 0;
        l2_addr = 0;
        while (cyc < 40) begin
            if (read_L1_L2) begin
                alloc++;
                if (alloc == 1) begin
                    rise_cyc = cyc;
                    l2_addr = address_L1_L2;
                end
                ready_L2_L1 = (alloc > l2_wait);
            end else begin
                ready_L2_L1 = 1'($urandom_range(1));
            end
            if (refill) begin
                nref++;
                ref_cyc = cyc;
                ref_way = way;
            end
            if (ready_L1_C) begin
                rdy_cyc = cyc;
                rdy_way = way;
                rdy_idx = index_C_L1;
                rdy_off = offset;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        ready_L2_L1 = 1'b0;
        chk("ready_seen", 32'(rdy_cyc != 0), 1);
        if (hit) begin
            chk("hit_latency", rdy_cyc, 1);
            chk("hit_no_l2", rise_cyc, 0);
        end else begin
            chk("miss_l2_rise", rise_cyc, 2);
            chk("miss_l2_addr", l2_addr, {a[31:6], 6'b0});
            chk("miss_refill_cyc", ref_cyc, 3 + l2_wait);
            chk("miss_refill_cnt", nref, 1);
            chk("miss_refill_way", 32'(ref_way), 32'(w));
            chk("miss_latency", rdy_cyc, 4 + l2_wait);
        end
        chk("ready_way", 32'(rdy_way), 32'(w));
        chk("ready_index", 32'(rdy_idx), 32'(s));
        chk("ready_offset", 32'(rdy_off), 32'(a[5:0]));
        @(negedge clk);
        chk("ready_strobe", 32'(ready_L1_C), 0);
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        read_C_L1 = 1'b1;
        address_C_L1 = 32'h1234_5044;
        @(negedge clk);
        flush = 1'b0;
        read_C_L1 = 1'b0;
        chk("flush_no_accept", {ready_L1_C, read_L1_L2, index_C_L1, offset}, 0);
        model_clear();
    endtask

    task automatic reset_in_allocate(input logic [31:0] a);
        int n;
        @(negedge clk);
        read_C_L1 = 1'b1;
        address_C_L1 = a;
        @(negedge clk);
        read_C_L1 = 1'b0;
        n = 0;
        while (!read_L1_L2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rstalloc_reached", 32'(read_L1_L2), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstalloc_read_low", 32'(read_L1_L2), 0);
        chk("rstalloc_outs", {ready_L1_C, refill, way, index_C_L1, offset}, 0);
        model_clear();
        ready_L2_L1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_l2_no_refill", {refill, read_L1_L2, ready_L1_C}, 0);
        end
        ready_L2_L1 = 1'b0;
    endtask

    initial begin
        logic [20:0] pool [4];
        logic [4:0]  idx;
        logic [20:0] tg;
        logic [31:0] a;
        pool[0] = 21'h091A2;
        pool[1] = 21'h1579B;
        pool[2] = 21'h0AAAA;
        pool[3] = 21'h1FFFF;
        model_clear();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {ready_L1_C, index_C_L1, offset, way, refill,
                           read_L1_L2}, 0);
        chk("reset_l2_addr", address_L1_L2, 0);
        rst = 1'b0;

        fetch(32'h1234_5048, 3);
        fetch(32'h1234_507C, 0);
        fetch(32'hABCD_E040, 1);
        fetch(32'h1234_5040, 0);
        fetch(32'h5555_5040, 2);
        fetch(32'h1234_5040, 0);
        do_flush();
        fetch(32'h1234_5040, 0);
        reset_in_allocate(32'hABCD_E040);
        fetch(32'h1234_5040, 1);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(11) == 0) begin
                do_flush();
            end else begin
                case ($urandom_range(3))
                    0: idx = 5'd0;
                    1: idx = 5'd31;
                    2: idx = 5'd1;
                    default: idx = 5'($urandom);
                endcase
                tg = pool[$urandom_range(3)];
                a = {tg, idx, 6'($urandom)};
                fetch(a, int'($urandom_range(3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
